// File: rtl/matmul_nxn_seq_pkg.sv
// ============================================================================
// matmul_pkg : shared state type and index helpers for the NxN multiplier
// rev 1.0
// ============================================================================
`default_nettype none

package matmul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Wide enough for a sum of n full-width products in either signedness.
  function automatic int acc_width(input int n, input int dw);
    return 2 * dw + $clog2(n) + 1;
  endfunction

  // Bit offset of element [i][j] in a row-major n x n bus of w-bit elements.
  function automatic int elem(input int n, input int i, input int j, input int w);
    return (i * n + j) * w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/matmul_nxn_seq_if.sv
// ============================================================================
// matmul_nxn_seq_if : start/busy/done handshake and flat operand/result buses
// rev 1.0
// ============================================================================
`default_nettype none

interface matmul_nxn_seq_if
  import matmul_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 8
);
  localparam int AW = acc_width(N, DW);

  logic                start;
  logic                signed_mode;
  logic                acc_mode;
  logic [N*N*DW-1:0]   a_flat;
  logic [N*N*DW-1:0]   b_flat;
  logic [N*N*AW-1:0]   c_flat;
  logic                busy;
  logic                done;

  modport master (
    output start, signed_mode, acc_mode, a_flat, b_flat,
    input  c_flat, busy, done
  );

  modport slave (
    input  start, signed_mode, acc_mode, a_flat, b_flat,
    output c_flat, busy, done
  );

endinterface

`default_nettype wire

// File: rtl/matmul_nxn_seq_mac_pe.sv
// ============================================================================
// matmul_mac_pe : one multiply-accumulate cell, signed or unsigned operands
// rev 1.0
// ============================================================================
`default_nettype none

module matmul_mac_pe
  import matmul_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = acc_width(3, 8)
) (
  input  wire logic          clk,
  input  wire logic          reset,
  input  wire logic          clr_load,
  input  wire logic [AW-1:0] load_val,
  input  wire logic          en,
  input  wire logic          signed_mode,
  input  wire logic [DW-1:0] a,
  input  wire logic [DW-1:0] b,
  output logic      [AW-1:0] acc
);

  localparam int PW = 2 * DW + 2;

  // One extra bit lets a single signed multiplier cover both modes.
  logic signed [DW:0]   a_ext;
  logic signed [DW:0]   b_ext;
  logic signed [PW-1:0] prod;

  assign a_ext = {signed_mode & a[DW-1], a};
  assign b_ext = {signed_mode & b[DW-1], b};
  assign prod  = PW'(a_ext) * PW'(b_ext);

  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (clr_load) begin
      acc <= load_val;
    end else if (en) begin
      acc <= acc + AW'(prod);
    end
  end

endmodule

`default_nettype wire

// File: rtl/matmul_nxn_seq.sv
// ============================================================================
// matmul_nxn_seq : NxN matrix multiplier, one k-slice per cycle on N*N MACs
// rev 1.0
// ============================================================================
`default_nettype none

module matmul_nxn_seq
  import matmul_pkg::*;
#(
  parameter int N  = 3,
  parameter int DW = 8
) (
  input  wire logic        clk,
  input  wire logic        reset,
  matmul_nxn_seq_if.slave  bus
);

  localparam int AW = acc_width(N, DW);
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int FW = N * N * DW;
  localparam int CW = N * N * AW;

  state_t          state;
  state_t          state_nxt;
  logic [KW-1:0]   k;
  logic [FW-1:0]   a_lat;
  logic [FW-1:0]   b_lat;
  logic            sm_lat;
  logic [CW-1:0]   c_reg;
  logic [CW-1:0]   acc_all;
  logic [AW-1:0]   acc_arr [N][N];
  logic            accept;
  logic            last_k;
  logic            run_en;

  assign accept = (state == IDLE) && bus.start;
  assign last_k = (k == KW'(N - 1));
  assign run_en = (state == RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (last_k)    state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_lat  <= '0;
      b_lat  <= '0;
      sm_lat <= 1'b0;
    end else if (accept) begin
      a_lat  <= bus.a_flat;
      b_lat  <= bus.b_flat;
      sm_lat <= bus.signed_mode;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      k <= '0;
    end else if (run_en) begin
      k <= last_k ? '0 : k + KW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_reg <= '0;
    end else if (state == DONE) begin
      c_reg <= acc_all;
    end
  end

  always_comb begin
    acc_all = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc_all[elem(N, i, j, AW) +: AW] = acc_arr[i][j];
      end
    end
  end

  // During DONE the accumulators already hold the final sums, so the result
  // is presented combinationally in that cycle and held from c_reg afterwards.
  assign bus.c_flat = (state == DONE) ? acc_all : c_reg;
  assign bus.busy   = (state != IDLE);
  assign bus.done   = (state == DONE);

  for (genvar i = 0; i < N; i++) begin : g_row
    logic [DW-1:0] a_sel;
    assign a_sel = a_lat[elem(N, i, int'(k), DW) +: DW];

    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0] b_sel;
      logic [AW-1:0] load_val;

      assign b_sel    = b_lat[elem(N, int'(k), j, DW) +: DW];
      assign load_val = bus.acc_mode ? c_reg[elem(N, i, j, AW) +: AW] : '0;

      matmul_mac_pe #(
        .DW (DW),
        .AW (AW)
      ) u_pe (
        .clk         (clk),
        .reset       (reset),
        .clr_load    (accept),
        .load_val    (load_val),
        .en          (run_en),
        .signed_mode (sm_lat),
        .a           (a_sel),
        .b           (b_sel),
        .acc         (acc_arr[i][j])
      );
    end
  end

endmodule

`default_nettype wire
